// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and encodings shared by the UART transmitter and receiver.
//   UART_CLKS_PER_BIT : default oversampling, clocks per UART bit
//   UART_DATA_BITS    : data bits per frame (8N1)
//   UART_STOP_BITS    : stop bits per frame
//   rx_state_e        : receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 32;
   localparam int UART_DATA_BITS    = 8;
   localparam int UART_STOP_BITS    = 1;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_sm_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
//   clk     : destination clock
//   reset   : synchronous, active-high; both flops load RESET_VAL
//   d_async : asynchronous input
//   q_sync  : synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic q_sync
);

   logic ff1_q;
   logic ff2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ff1_q <= RESET_VAL;
         ff2_q <= RESET_VAL;
      end else begin
         ff1_q <= d_async;
         ff2_q <= ff1_q;
      end
   end

   assign q_sync = ff2_q;

endmodule

// File: rtl/uart_sm_rx.sv
// ---------------------------------------------------------------------------
// uart_sm_rx
// 8N1 UART receiver, LSB first, CLKS_PER_BIT clocks per bit, mid-bit sampling.
//   clk         : clock
//   reset       : synchronous, active-high
//   rx          : asynchronous serial line, idle high
//   byte_out    : last correctly framed byte; holds until the next one
//   byte_valid  : one-cycle strobe, byte_out updated in the same cycle
//   frame_error : one-cycle strobe, stop bit sampled low
//   busy        : high whenever the FSM is not idle
// CLKS_PER_BIT must be even, >= 4, and equal to the transmitter's setting.
//
// Handshake: byte_valid is a pure strobe with no ready; the consumer must
// capture byte_out in the cycle byte_valid is high. byte_valid and
// frame_error are mutually exclusive.
// ---------------------------------------------------------------------------
module uart_sm_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .d_async (rx),
      .q_sync  (rx_s)
   );

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               // The cycle that detects the falling edge is the first cycle
               // of the half-bit wait, so the count starts at one.
               cnt_d   = CNT_W'(1);
            end
         end

         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  // Line went back high before mid-start-bit: a glitch.
                  state_d = RX_IDLE;
               end else begin
                  state_d   = RX_DATA;
                  bit_idx_d = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = RX_STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Leaving at mid-stop-bit leaves half a bit of margin for a
               // back-to-back start edge.
               if (rx_s) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RX_BREAK: begin
            // Hold off until the line recovers so a held-low line does not
            // look like an endless stream of start bits.
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end

         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != RX_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign byte_out    = byte_q;
   assign byte_valid  = valid_q;
   assign frame_error = ferr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_sm_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_sm_rx
// Directed bench for uart_sm_rx with the default 32 clocks per bit.
// Inputs change 1 time unit after a rising edge; outputs are observed on the
// falling edge. If rx first goes low at cycle number t0, the capturing edge
// A is t0+1, so a frame strobe lands on edge number t0+306.
// ---------------------------------------------------------------------------
module tb_uart_sm_rx;

   localparam int CPB = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_error;
   logic       busy;

   uart_sm_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .frame_error (frame_error),
      .busy        (busy)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];

   int vld_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int last_vld_cyc = 0;
   int prev_vld_cyc = 0;
   int last_fe_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives the first ncyc cycles of an 8N1 frame waveform.
   task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         rx = f[c / CPB];
         hold(1);
      end
   endtask

   // Scoreboard / pulse monitor.
   always @(negedge clk) begin
      if (byte_valid) begin
         vld_cnt      <= vld_cnt + 1;
         prev_vld_cyc <= last_vld_cyc;
         last_vld_cyc <= cyc;
         n_vec++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL sb_unexpected_valid: observed byte %0h expected no strobe", byte_out);
         end
         if (exp_q.size() != 0) chk("sb_byte", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
      end
      if (frame_error) begin
         fe_cnt      <= fe_cnt + 1;
         last_fe_cyc <= cyc;
      end
      if (byte_valid && frame_error) both_cnt <= both_cnt + 1;
   end

   int t0;
   int t1;
   logic [7:0] lb_bytes [4];

   initial begin
      lb_bytes[0] = 8'h00;
      lb_bytes[1] = 8'h55;
      lb_bytes[2] = 8'hAA;
      lb_bytes[3] = 8'hFF;

      // reset state
      reset = 1'b1;
      hold(3);
      chk("rst_byte_out", {24'h0, byte_out}, 32'h00);
      chk("rst_valid", {31'h0, byte_valid}, 32'h0);
      chk("rst_ferr", {31'h0, frame_error}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      hold(5);

      // single frame 0xA5
      t0 = cyc;
      exp_q.push_back(8'hA5);
      drive_frame(8'hA5, 1'b1, 10 * CPB);
      chk("a5_vld_cnt", vld_cnt, 1);
      chk("a5_vld_cyc", last_vld_cyc, t0 + 306);
      chk("a5_byte", {24'h0, byte_out}, 32'hA5);
      chk("a5_fe_cnt", fe_cnt, 0);
      chk("a5_busy", {31'h0, busy}, 32'h0);
      hold(10);

      // back-to-back 0x00, 0xFF
      t0 = cyc;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      drive_frame(8'h00, 1'b1, 10 * CPB);
      t1 = cyc;
      chk("b2b_gap0", t1 - t0, 320);
      drive_frame(8'hFF, 1'b1, 10 * CPB);
      chk("b2b_vld_cnt", vld_cnt, 3);
      chk("b2b_first_cyc", prev_vld_cyc, t0 + 306);
      chk("b2b_second_cyc", last_vld_cyc, t0 + 626);
      chk("b2b_byte", {24'h0, byte_out}, 32'hFF);
      hold(20);

      // 10-cycle low glitch
      rx = 1'b0;
      hold(10);
      rx = 1'b1;
      chk("glitch_busy_hi", {31'h0, busy}, 32'h1);
      hold(20);
      chk("glitch_busy_lo", {31'h0, busy}, 32'h0);
      chk("glitch_vld_cnt", vld_cnt, 3);
      chk("glitch_fe_cnt", fe_cnt, 0);
      chk("glitch_byte", {24'h0, byte_out}, 32'hFF);
      hold(10);

      // bad stop bit, line held low, then recovery
      t0 = cyc;
      drive_frame(8'h3C, 1'b0, 10 * CPB);
      hold(200);
      chk("fe_cnt", fe_cnt, 1);
      chk("fe_cyc", last_fe_cyc, t0 + 306);
      chk("fe_vld_cnt", vld_cnt, 3);
      chk("fe_break_busy", {31'h0, busy}, 32'h1);
      chk("fe_byte", {24'h0, byte_out}, 32'hFF);
      hold(200);
      chk("fe_break_busy2", {31'h0, busy}, 32'h1);
      rx = 1'b1;
      hold(5);
      chk("fe_idle_busy", {31'h0, busy}, 32'h0);
      hold(10);
      t0 = cyc;
      exp_q.push_back(8'h81);
      drive_frame(8'h81, 1'b1, 10 * CPB);
      chk("r81_vld_cnt", vld_cnt, 4);
      chk("r81_vld_cyc", last_vld_cyc, t0 + 306);
      chk("r81_byte", {24'h0, byte_out}, 32'h81);
      chk("r81_fe_cnt", fe_cnt, 1);
      hold(10);

      // reset in the middle of data bit 4
      drive_frame(8'h6E, 1'b1, 5 * CPB + 16);
      chk("mid_busy", {31'h0, busy}, 32'h1);
      reset = 1'b1;
      hold(1);
      chk("mid_rst_byte", {24'h0, byte_out}, 32'h00);
      chk("mid_rst_valid", {31'h0, byte_valid}, 32'h0);
      chk("mid_rst_ferr", {31'h0, frame_error}, 32'h0);
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b0;
      rx = 1'b1;
      hold(400);
      chk("mid_vld_cnt", vld_cnt, 4);
      chk("mid_fe_cnt", fe_cnt, 1);
      t0 = cyc;
      exp_q.push_back(8'h5A);
      drive_frame(8'h5A, 1'b1, 10 * CPB);
      chk("r5a_vld_cnt", vld_cnt, 5);
      chk("r5a_vld_cyc", last_vld_cyc, t0 + 306);
      chk("r5a_byte", {24'h0, byte_out}, 32'h5A);
      hold(10);

      // transmitter-style stream: 320-cycle frame plus one idle cycle
      for (int k = 0; k < 4; k++) begin
         t0 = cyc;
         exp_q.push_back(lb_bytes[k]);
         drive_frame(lb_bytes[k], 1'b1, 10 * CPB);
         rx = 1'b1;
         hold(1);
         chk("lb_vld_cyc", last_vld_cyc, t0 + 306);
         chk("lb_byte", {24'h0, byte_out}, {24'h0, lb_bytes[k]});
      end
      hold(10);
      chk("lb_vld_cnt", vld_cnt, 9);
      chk("lb_fe_cnt", fe_cnt, 1);
      chk("both_pulses", both_cnt, 0);
      chk("sb_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
